hazard_detect_unit: RTL and testbench
=====================================

Name: hazard_detect_unit

Overview:
- Control-side counterpart of the ID/EX pipeline register in the 5-stage RV32I core.
- Detects load-use data hazards between the instruction in ID (the IF/ID instruction) and the instruction in EX (the ID/EX outputs).
- Detects taken branches and jumps resolved in EX.
- Drives PC/IF-ID write enables, the IF/ID flush and the ID/EX bubble (Flush_HD). Keeps saturating stall and flush event counters for performance reporting.

Parameters:
- LOAD_STALL, 1, number of bubble cycles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  core clock; the state and counters update on the rising edge.
- rst  input  1  synchronous, active-low reset.
- id_inst_i  input  32  instruction currently held in IF/ID.
- ex_memRead_i  input  1  memRead of the instruction in EX (ID/EX output).
- ex_rd_i  input  5  rd of the instruction in EX (ID/EX inst bits 11:7).
- ex_branch_taken_i  input  1  the branch/jal/jalr in EX redirects the PC this cycle.
- pcWrite_o  output  1  PC update enable.
- ifidWrite_o  output  1  IF/ID load enable.
- ifidFlush_o  output  1  IF/ID loads a NOP (0x00000013).
- Flush_HD_o  output  1  ID/EX loads a bubble; drives the Flush_HD input of ID/EX.
- stall_cnt_o  output  CNT_W  bubble cycles inserted for load-use hazards, saturating.
- flush_cnt_o  output  CNT_W  taken-branch flush events, saturating.

Behaviour:
- FSM states: RUN, STALL. Internal down-counter rem (3 bits).
- Operand use, decoded from id_inst_i[6:0]:
  - rs1 (bits 19:15) is used by R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jalr 1100111.
  - rs2 (bits 24:20) is used by R, store and branch.
  - lui, auipc and jal use neither. Unknown opcodes use neither.
- hazard = ex_memRead_i AND ex_rd_i != 0 AND ((use_rs1 AND rs1 == ex_rd_i) OR (use_rs2 AND rs2 == ex_rd_i)).
- Outputs are combinational from state and inputs (same-cycle effect), evaluated in priority order:
  1. ex_branch_taken_i=1, any state: pcWrite=1, ifidWrite=1, ifidFlush=1, Flush_HD=1. Next state is RUN and rem is cleared. Branch always wins over a hazard or an in-progress stall.
  2. RUN with hazard: pcWrite=0, ifidWrite=0, ifidFlush=0, Flush_HD=1.
     - If LOAD_STALL>1: next state STALL with rem=LOAD_STALL-1.
     - Otherwise remain in RUN (the load has moved to MEM next cycle, so the hazard clears naturally).
  3. STALL: pcWrite=0, ifidWrite=0, Flush_HD=1, rem decrements. When rem==1 is consumed, next state is RUN. The hazard input is ignored while in STALL.
  4. RUN, no hazard, no branch: pcWrite=1, ifidWrite=1, ifidFlush=0, Flush_HD=0.
- Counters:
  - stall_cnt increments by 1 in every cycle where Flush_HD=1 due to rule 2 or rule 3.
  - flush_cnt increments by 1 in every cycle where rule 1 applies.
  - Both saturate at all-ones; there is no wrap.
- Reset (rst=0 sampled at a rising edge): state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
  - While rst=0, outputs are forced to pcWrite=1, ifidWrite=1, ifidFlush=0, Flush_HD=0, regardless of the other inputs.
  - Reset asserted mid-STALL aborts the stall immediately; the cycle after release is RUN.
- ex_rd_i==0 never causes a stall (x0 is not a real dependency), even with memRead set.
- Pipeline registers capture on the falling edge. The combinational outputs must therefore be stable before the negedge of the same cycle; no output register is inserted.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_INST = 32'h00000013;
  - the hd_state_t enum {RUN, STALL}.
- One natural sub-module: hd_operand_use, a combinational decoder from opcode to {use_rs1, use_rs2}. It is reused later by the forwarding unit.

Test Plan:
1. rst=0 for 2 cycles with ex_branch_taken_i=1 and a hazard present -> pcWrite=1, ifidWrite=1, both flushes 0; after release both counters read 0.
2. EX is lw x5 (memRead=1, rd=5) and ID is add x6,x5,x7 (0x00728333), LOAD_STALL=1 -> exactly 1 cycle of pcWrite=0, ifidWrite=0, Flush_HD=1; next cycle memRead=0 gives normal flow; stall_cnt=1.
3. Same stimulus with LOAD_STALL=3 -> 3 consecutive bubble cycles, state RUN on the 4th cycle, stall_cnt=3. Then ID=lui x5 (use neither) with the same EX -> no stall.
4. EX is lw x0 and ID is add x6,x0,x0 -> no stall. EX is lw x5 and ID is sw x5,0(x9) (rs2 match) -> stall.
5. LOAD_STALL=3, in the 2nd STALL cycle raise ex_branch_taken_i -> same-cycle ifidFlush=1, Flush_HD=1, pcWrite=1; next cycle RUN; stall_cnt=1, flush_cnt=1.
6. CNT_W=4, 20 consecutive taken branches -> flush_cnt stops at 15 with no wrap. Reset mid-STALL -> RUN and counters 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, the canonical NOP and the hazard unit state type.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hd_state_t;

endpackage

// File: rtl/hazard_detect_unit_if.sv
// Pipeline-side view of the hazard detection unit: ID/EX observations in, stall/flush controls out.
interface hazard_detect_unit_if;

    logic [31:0] id_inst_i;
    logic        ex_memRead_i;
    logic [4:0]  ex_rd_i;
    logic        ex_branch_taken_i;

    logic        pcWrite_o;
    logic        ifidWrite_o;
    logic        ifidFlush_o;
    logic        Flush_HD_o;

    modport master (
        output id_inst_i,
        output ex_memRead_i,
        output ex_rd_i,
        output ex_branch_taken_i,
        input  pcWrite_o,
        input  ifidWrite_o,
        input  ifidFlush_o,
        input  Flush_HD_o
    );

    modport slave (
        input  id_inst_i,
        input  ex_memRead_i,
        input  ex_rd_i,
        input  ex_branch_taken_i,
        output pcWrite_o,
        output ifidWrite_o,
        output ifidFlush_o,
        output Flush_HD_o
    );

endinterface

// File: rtl/hazard_detect_unit_operand_use.sv
// Decodes which source register fields an RV32I opcode actually reads.
module hd_operand_use
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2
);

    // lui, auipc, jal and any unrecognised opcode read no registers.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use hazard and taken-branch control for the 5-stage core, with saturating
// stall/flush event counters. Controls are combinational so they settle before the negedge capture.
module hazard_detect_unit
    import core_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_detect_unit_if.slave hd,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);

    hd_state_t        state;
    hd_state_t        state_next;
    logic [2:0]       rem;
    logic [2:0]       rem_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       hazard;
    logic       stall_evt;
    logic       flush_evt;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       flush_hd;
    logic       unused_inst_bits;

    hd_operand_use u_operand_use (
        .opcode  (hd.id_inst_i[6:0]),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign rs1              = hd.id_inst_i[19:15];
    assign rs2              = hd.id_inst_i[24:20];
    assign unused_inst_bits = ^{hd.id_inst_i[31:25], hd.id_inst_i[14:7]};

    // x0 is hardwired, so a load targeting it is never a real dependency.
    assign hazard = hd.ex_memRead_i && (hd.ex_rd_i != 5'd0) &&
                    ((use_rs1 && (rs1 == hd.ex_rd_i)) ||
                     (use_rs2 && (rs2 == hd.ex_rd_i)));

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        flush_hd   = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        state_next = state;
        rem_next   = rem;

        if (!rst) begin
            state_next = RUN;
            rem_next   = 3'd0;
        end else if (hd.ex_branch_taken_i) begin
            // A redirect squashes everything younger, including a pending stall.
            ifid_flush = 1'b1;
            flush_hd   = 1'b1;
            flush_evt  = 1'b1;
            state_next = RUN;
            rem_next   = 3'd0;
        end else if (state == RUN && hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_hd   = 1'b1;
            stall_evt  = 1'b1;
            if (LOAD_STALL > 1) begin
                state_next = STALL;
                rem_next   = REM_INIT;
            end
        end else if (state == STALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_hd   = 1'b1;
            stall_evt  = 1'b1;
            rem_next   = (rem == 3'd0) ? 3'd0 : rem - 3'd1;
            if (rem <= 3'd1) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            rem       <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hd.pcWrite_o   = pc_write;
    assign hd.ifidWrite_o = ifid_write;
    assign hd.ifidFlush_o = ifid_flush;
    assign hd.Flush_HD_o  = flush_hd;
    assign stall_cnt_o    = stall_cnt;
    assign flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: three instances (LOAD_STALL=1, LOAD_STALL=3, and
// LOAD_STALL=3 with 4-bit counters) see identical stimulus; flags are {pcWrite, ifidWrite, ifidFlush, Flush_HD}.
module tb_hazard_detect_unit;
    import core_pkg::*;

    localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
    localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
    localparam logic [31:0] LUI_X5_RS5   = 32'h000282B7;
    localparam logic [31:0] SW_X5_0_X9   = 32'h0054A023;
    localparam logic [31:0] ADDI_X6_X1_5 = 32'h00508313;
    localparam logic [31:0] JALR_X1_X5   = 32'h000280E7;

    localparam logic [3:0] NORM = 4'b1100;
    localparam logic [3:0] BUBL = 4'b0001;
    localparam logic [3:0] BRFL = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    int   vector_cnt = 0;
    int   miss_cnt   = 0;

    logic [15:0] stall1, flush1, stall3, flush3;
    logic [3:0]  stall4, flush4;

    always #5 clk = ~clk;

    hazard_detect_unit_if if1 ();
    hazard_detect_unit_if if3 ();
    hazard_detect_unit_if if4 ();

    hazard_detect_unit #(.LOAD_STALL(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .hd(if1), .stall_cnt_o(stall1), .flush_cnt_o(flush1)
    );
    hazard_detect_unit #(.LOAD_STALL(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .hd(if3), .stall_cnt_o(stall3), .flush_cnt_o(flush3)
    );
    hazard_detect_unit #(.LOAD_STALL(3), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .hd(if4), .stall_cnt_o(stall4), .flush_cnt_o(flush4)
    );

    function automatic logic [3:0] flags1();
        return {if1.pcWrite_o, if1.ifidWrite_o, if1.ifidFlush_o, if1.Flush_HD_o};
    endfunction

    function automatic logic [3:0] flags3();
        return {if3.pcWrite_o, if3.ifidWrite_o, if3.ifidFlush_o, if3.Flush_HD_o};
    endfunction

    function automatic logic [3:0] flags4();
        return {if4.pcWrite_o, if4.ifidWrite_o, if4.ifidFlush_o, if4.Flush_HD_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_cnt++;
        if (observed !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] e1, input logic [3:0] e3, input logic [3:0] e4);
        checkOutput({tag, "_u1"}, 32'(flags1()), 32'(e1));
        checkOutput({tag, "_u3"}, 32'(flags3()), 32'(e3));
        checkOutput({tag, "_u4"}, 32'(flags4()), 32'(e4));
    endtask

    task automatic driveInputs(input logic r, input logic [31:0] inst, input logic mr,
                               input logic [4:0] rd, input logic br);
        rst                   = r;
        if1.id_inst_i         = inst;
        if1.ex_memRead_i      = mr;
        if1.ex_rd_i           = rd;
        if1.ex_branch_taken_i = br;
        if3.id_inst_i         = inst;
        if3.ex_memRead_i      = mr;
        if3.ex_rd_i           = rd;
        if3.ex_branch_taken_i = br;
        if4.id_inst_i         = inst;
        if4.ex_memRead_i      = mr;
        if4.ex_rd_i           = rd;
        if4.ex_branch_taken_i = br;
    endtask

    // One cycle: new inputs land just after the rising edge and are checked well before the negedge.
    task automatic applyStimulus(input logic r, input logic [31:0] inst, input logic mr,
                                 input logic [4:0] rd, input logic br);
        @(posedge clk);
        #1;
        driveInputs(r, inst, mr, rd, br);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, NOP_INST, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        driveInputs(1'b0, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1);

        applyStimulus(1'b0, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1);
        checkAll("rst_c1", NORM, NORM, NORM);
        applyStimulus(1'b0, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1);
        checkAll("rst_c2", NORM, NORM, NORM);
        idleCycle();
        checkAll("post_rst", NORM, NORM, NORM);
        checkOutput("post_rst_stall1", 32'(stall1), 32'd0);
        checkOutput("post_rst_flush1", 32'(flush1), 32'd0);
        checkOutput("post_rst_stall3", 32'(stall3), 32'd0);
        checkOutput("post_rst_flush3", 32'(flush3), 32'd0);
        checkOutput("post_rst_stall4", 32'(stall4), 32'd0);
        checkOutput("post_rst_flush4", 32'(flush4), 32'd0);

        // lw x5 in EX, add x6,x5,x7 in ID; the load leaves EX afterwards
        applyStimulus(1'b1, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0);
        checkAll("lu_c1", BUBL, BUBL, BUBL);
        idleCycle();
        checkAll("lu_c2", NORM, BUBL, BUBL);
        checkOutput("lu_stall1", 32'(stall1), 32'd1);
        idleCycle();
        checkAll("lu_c3", NORM, BUBL, BUBL);
        idleCycle();
        checkAll("lu_c4", NORM, NORM, NORM);
        checkOutput("lu_stall1_end", 32'(stall1), 32'd1);
        checkOutput("lu_stall3_end", 32'(stall3), 32'd3);

        applyStimulus(1'b1, LUI_X5_RS5, 1'b1, 5'd5, 1'b0);
        checkAll("lui_nouse", NORM, NORM, NORM);
        applyStimulus(1'b1, ADD_X6_X0_X0, 1'b1, 5'd0, 1'b0);
        checkAll("rd_x0", NORM, NORM, NORM);

        applyStimulus(1'b1, SW_X5_0_X9, 1'b1, 5'd5, 1'b0);
        checkAll("sw_rs2_c1", BUBL, BUBL, BUBL);
        idleCycle();
        checkAll("sw_rs2_c2", NORM, BUBL, BUBL);
        idleCycle();
        checkAll("sw_rs2_c3", NORM, BUBL, BUBL);
        idleCycle();
        checkAll("sw_rs2_c4", NORM, NORM, NORM);
        checkOutput("sw_stall1", 32'(stall1), 32'd2);
        checkOutput("sw_stall3", 32'(stall3), 32'd6);

        applyStimulus(1'b1, ADDI_X6_X1_5, 1'b1, 5'd5, 1'b0);
        checkAll("imm_no_rs2", NORM, NORM, NORM);
        applyStimulus(1'b1, ADD_X6_X5_X7, 1'b0, 5'd5, 1'b0);
        checkAll("no_memread", NORM, NORM, NORM);
        applyStimulus(1'b1, ADD_X6_X5_X7, 1'b1, 5'd8, 1'b0);
        checkAll("rd_nomatch", NORM, NORM, NORM);
        applyStimulus(1'b1, JALR_X1_X5, 1'b1, 5'd5, 1'b0);
        checkAll("jalr_c1", BUBL, BUBL, BUBL);
        idleCycle();
        checkAll("jalr_c2", NORM, BUBL, BUBL);
        idleCycle();
        checkAll("jalr_c3", NORM, BUBL, BUBL);
        idleCycle();
        checkAll("jalr_c4", NORM, NORM, NORM);
        checkOutput("jalr_stall1", 32'(stall1), 32'd3);
        checkOutput("jalr_stall3", 32'(stall3), 32'd9);
        checkOutput("jalr_stall4", 32'(stall4), 32'd9);

        // Branch arriving in the second bubble cycle cancels the rest of the stall
        applyStimulus(1'b0, NOP_INST, 1'b0, 5'd0, 1'b0);
        checkAll("br_rst", NORM, NORM, NORM);
        applyStimulus(1'b1, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0);
        checkAll("br_c1", BUBL, BUBL, BUBL);
        applyStimulus(1'b1, NOP_INST, 1'b0, 5'd0, 1'b1);
        checkAll("br_c2", BRFL, BRFL, BRFL);
        idleCycle();
        checkAll("br_c3", NORM, NORM, NORM);
        checkOutput("br_stall3", 32'(stall3), 32'd1);
        checkOutput("br_flush3", 32'(flush3), 32'd1);
        checkOutput("br_stall1", 32'(stall1), 32'd1);
        checkOutput("br_flush1", 32'(flush1), 32'd1);
        checkOutput("br_flush4", 32'(flush4), 32'd1);
        idleCycle();
        checkAll("br_c4", NORM, NORM, NORM);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, NOP_INST, 1'b0, 5'd0, 1'b1);
            checkOutput("sat_flags_u4", 32'(flags4()), 32'(BRFL));
            if (i == 14) begin
                checkOutput("sat_reach_u4", 32'(flush4), 32'd15);
            end
        end
        idleCycle();
        checkOutput("sat_flush4", 32'(flush4), 32'd15);
        checkOutput("sat_flush1", 32'(flush1), 32'd21);
        checkOutput("sat_flush3", 32'(flush3), 32'd21);

        // Reset in the middle of a stall aborts it
        applyStimulus(1'b1, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0);
        checkAll("mid_c1", BUBL, BUBL, BUBL);
        applyStimulus(1'b0, ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1);
        checkAll("mid_rst", NORM, NORM, NORM);
        idleCycle();
        checkAll("mid_after", NORM, NORM, NORM);
        checkOutput("mid_stall3", 32'(stall3), 32'd0);
        checkOutput("mid_flush3", 32'(flush3), 32'd0);
        checkOutput("mid_stall4", 32'(stall4), 32'd0);
        checkOutput("mid_flush4", 32'(flush4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_cnt, miss_cnt);
        $finish;
    end

endmodule
